// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS control unit: opcode/funct codes,
// ALU function codes, instruction classes and controller states.
package mips_ctrl_pkg;

    localparam int ALU_OP_WIDTH = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_e;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_RTYPE,
        CLS_JR,
        CLS_HALT,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_ILLEGAL
    } inst_class_e;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

endpackage

// File: rtl/mips_ctrl_if.sv
// Control-unit <-> datapath signal bundle. The master side is the controller.
// illegal_inst exists only when MIPS_CTRL_ILLEGAL_TRAP_EN is defined.
interface mips_ctrl_if #(
    parameter int ALU_OP_W = 4
);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                pc_write;
    logic                ir_write;
    logic                memOrReg;
    logic                aluSrc;
    logic [ALU_OP_W-1:0] alu_operation;
    logic                reg_write_enable;
    logic                regDest;
    logic                branch;
    logic                branch_ne;
    logic                jump;
    logic                jump_register;
    logic                mem_write_en;
    logic                halted;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic                illegal_inst;
`endif

    modport master (
        input  opcode, funct,
        output pc_write, ir_write, memOrReg, aluSrc, alu_operation,
        output reg_write_enable, regDest, branch, branch_ne, jump,
        output jump_register, mem_write_en, halted
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        , output illegal_inst
`endif
    );

    modport slave (
        output opcode, funct,
        input  pc_write, ir_write, memOrReg, aluSrc, alu_operation,
        input  reg_write_enable, regDest, branch, branch_ne, jump,
        input  jump_register, mem_write_en, halted
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        , input illegal_inst
`endif
    );

endinterface

// File: rtl/mips_ctrl_decoder.sv
// Combinational instruction decoder: opcode/funct -> instruction class and ALU op.
module mips_ctrl_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output inst_class_e inst_class,
    output alu_op_e     alu_op
);

    always_comb begin
        inst_class = CLS_ILLEGAL;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:     begin inst_class = CLS_RTYPE; alu_op = ALU_ADD; end
                    FN_SUB:     begin inst_class = CLS_RTYPE; alu_op = ALU_SUB; end
                    FN_AND:     begin inst_class = CLS_RTYPE; alu_op = ALU_AND; end
                    FN_OR:      begin inst_class = CLS_RTYPE; alu_op = ALU_OR;  end
                    FN_SLT:     begin inst_class = CLS_RTYPE; alu_op = ALU_SLT; end
                    FN_JR:      inst_class = CLS_JR;
                    FN_SYSCALL: inst_class = CLS_HALT;
                    default:    inst_class = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI: inst_class = CLS_ADDI;
            OP_LW:   inst_class = CLS_LW;
            OP_SW:   inst_class = CLS_SW;
            OP_BEQ:  begin inst_class = CLS_BEQ; alu_op = ALU_SUB; end
            OP_BNE:  begin inst_class = CLS_BNE; alu_op = ALU_SUB; end
            OP_J:    inst_class = CLS_J;
            default: inst_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control unit with a fixed-latency data-memory stall.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to halt on illegal instructions (adds illegal_inst).
//
// state  | meaning
// FETCH  | ir_write, instruction register loads
// DECODE | latch class/alu op; jumps retire here
// EXEC   | ALU operation; branches retire here
// MEM    | data-memory access, MEM_LATENCY cycles
// WB     | register-file write, PC update
// HALT   | stopped until reset
module mips_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ALU_OP_W    = 4
) (
    input  logic      clk,
    input  logic      rst_b,
    mips_ctrl_if.master bus
);

    localparam logic [3:0] MEM_LAST = 4'(MEM_LATENCY - 1);

    state_e      state_q, state_d;
    inst_class_e cls_q, cls_d;
    alu_op_e     alu_q, alu_d;
    logic [3:0]  cnt_q, cnt_d;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic        illegal_q, illegal_d;
`endif

    inst_class_e dec_cls;
    alu_op_e     dec_alu;

    logic    pcw_c, irw_c, mor_c, asrc_c, rwe_c, rdst_c;
    logic    br_c, bne_c, j_c, jr_c, mwe_c, hlt_c;
    alu_op_e alu_c;

    mips_ctrl_decoder u_decoder (
        .opcode     (bus.opcode),
        .funct      (bus.funct),
        .inst_class (dec_cls),
        .alu_op     (dec_alu)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q   <= FETCH;
            cls_q     <= CLS_NOP;
            alu_q     <= ALU_ADD;
            cnt_q     <= '0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_q     <= alu_d;
            cnt_q     <= cnt_d;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_d     = alu_q;
        cnt_d     = cnt_q;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        pcw_c  = 1'b0;
        irw_c  = 1'b0;
        mor_c  = 1'b0;
        asrc_c = 1'b0;
        rwe_c  = 1'b0;
        rdst_c = 1'b0;
        br_c   = 1'b0;
        bne_c  = 1'b0;
        j_c    = 1'b0;
        jr_c   = 1'b0;
        mwe_c  = 1'b0;
        hlt_c  = 1'b0;
        alu_c  = ALU_ADD;

        case (state_q)
            FETCH: begin
                irw_c   = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                // opcode is only valid from DECODE on, so this state acts on the live decode
                cls_d = dec_cls;
                alu_d = dec_alu;
                case (dec_cls)
                    CLS_J:    begin j_c  = 1'b1; pcw_c = 1'b1; state_d = FETCH; end
                    CLS_JR:   begin jr_c = 1'b1; pcw_c = 1'b1; state_d = FETCH; end
                    CLS_HALT: state_d = HALT;
                    CLS_ILLEGAL: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = HALT;
`else
                        pcw_c   = 1'b1;
                        state_d = FETCH;
`endif
                    end
                    default:  state_d = EXEC;
                endcase
            end
            EXEC: begin
                alu_c  = alu_q;
                asrc_c = (cls_q == CLS_ADDI) || (cls_q == CLS_LW) || (cls_q == CLS_SW);
                case (cls_q)
                    CLS_BEQ, CLS_BNE: begin
                        br_c    = 1'b1;
                        bne_c   = (cls_q == CLS_BNE);
                        pcw_c   = 1'b1;
                        state_d = FETCH;
                    end
                    CLS_LW, CLS_SW: begin
                        cnt_d   = '0;
                        state_d = MEM;
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                asrc_c = 1'b1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == MEM_LAST) begin
                    if (cls_q == CLS_SW) begin
                        mwe_c   = 1'b1;
                        pcw_c   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rwe_c   = 1'b1;
                pcw_c   = 1'b1;
                rdst_c  = (cls_q == CLS_RTYPE);
                mor_c   = (cls_q == CLS_LW);
                state_d = FETCH;
            end
            HALT: hlt_c = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    // Everything is forced low while reset is held, including a pending write.
    assign bus.pc_write         = rst_b & pcw_c;
    assign bus.ir_write         = rst_b & irw_c;
    assign bus.memOrReg         = rst_b & mor_c;
    assign bus.aluSrc           = rst_b & asrc_c;
    assign bus.alu_operation    = rst_b ? ALU_OP_W'(alu_c) : '0;
    assign bus.reg_write_enable = rst_b & rwe_c;
    assign bus.regDest          = rst_b & rdst_c;
    assign bus.branch           = rst_b & br_c;
    assign bus.branch_ne        = rst_b & bne_c;
    assign bus.jump             = rst_b & j_c;
    assign bus.jump_register    = rst_b & jr_c;
    assign bus.mem_write_en     = rst_b & mwe_c;
    assign bus.halted           = rst_b & hlt_c;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal_inst     = rst_b & illegal_q;
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Bench for mips_ctrl_fsm: two instances (MEM_LATENCY 3 and 1) share stimulus and
// are compared against a per-instruction cycle-trace model built from the ISA rules.
module tb_mips_ctrl_fsm;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    mips_ctrl_if #(.ALU_OP_W(4)) if3 ();
    mips_ctrl_if #(.ALU_OP_W(4)) if1 ();

    mips_ctrl_fsm #(.MEM_LATENCY(3), .ALU_OP_W(4)) dut3 (.clk(clk), .rst_b(rst_b), .bus(if3));
    mips_ctrl_fsm #(.MEM_LATENCY(1), .ALU_OP_W(4)) dut1 (.clk(clk), .rst_b(rst_b), .bus(if1));

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic       pcw, irw, mor, asrc;
        logic [3:0] alu;
        logic       rwe, rdst, br, bne, j, jr, mwe, hlt, ill;
    } vec_t;
    typedef vec_t trace_t[$];

    typedef enum {M_R, M_JR, M_HALT, M_ADDI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_ILL} mcls_t;

    typedef struct {
        string      name;
        logic [5:0] op, fn;
        int         c3, c1;
    } row_t;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t sample(input bit sel);
        vec_t v;
        v.pcw  = sel ? if1.pc_write         : if3.pc_write;
        v.irw  = sel ? if1.ir_write         : if3.ir_write;
        v.mor  = sel ? if1.memOrReg         : if3.memOrReg;
        v.asrc = sel ? if1.aluSrc           : if3.aluSrc;
        v.alu  = sel ? if1.alu_operation    : if3.alu_operation;
        v.rwe  = sel ? if1.reg_write_enable : if3.reg_write_enable;
        v.rdst = sel ? if1.regDest          : if3.regDest;
        v.br   = sel ? if1.branch           : if3.branch;
        v.bne  = sel ? if1.branch_ne        : if3.branch_ne;
        v.j    = sel ? if1.jump             : if3.jump;
        v.jr   = sel ? if1.jump_register    : if3.jump_register;
        v.mwe  = sel ? if1.mem_write_en     : if3.mem_write_en;
        v.hlt  = sel ? if1.halted           : if3.halted;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        v.ill  = sel ? if1.illegal_inst     : if3.illegal_inst;
`else
        v.ill  = 1'b0;
`endif
        return v;
    endfunction

    task automatic check_vec(input string name, input int cyc, input int lat, input vec_t got, input vec_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d lat %0d: got %h expected %h", name, cyc, lat, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic mcls_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) return M_R;
                if (fn == 6'h08) return M_JR;
                if (fn == 6'h0C) return M_HALT;
                return M_ILL;
            end
            6'h08:   return M_ADDI;
            6'h23:   return M_LW;
            6'h2B:   return M_SW;
            6'h04:   return M_BEQ;
            6'h05:   return M_BNE;
            6'h02:   return M_J;
            default: return M_ILL;
        endcase
    endfunction

    function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'd1;
            6'h24:   return 4'd2;
            6'h25:   return 4'd3;
            6'h2A:   return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    function automatic bit halts(input logic [5:0] op, input logic [5:0] fn);
        mcls_t c = classify(op, fn);
        return (c == M_HALT) || (c == M_ILL && TRAP);
    endfunction

    // Expected outputs, one entry per cycle, from FETCH to the last cycle of the instruction.
    function automatic trace_t build(input logic [5:0] op, input logic [5:0] fn, input int lat);
        trace_t t;
        vec_t   v;
        mcls_t  c = classify(op, fn);
        v = '0; v.irw = 1'b1; t.push_back(v);
        v = '0;
        if (c == M_J) begin
            v.j = 1'b1; v.pcw = 1'b1; t.push_back(v);
        end else if (c == M_JR) begin
            v.jr = 1'b1; v.pcw = 1'b1; t.push_back(v);
        end else if (c == M_ILL && !TRAP) begin
            v.pcw = 1'b1; t.push_back(v);
        end else if (halts(op, fn)) begin
            t.push_back(v);
            v.hlt = 1'b1; v.ill = (c == M_ILL);
            repeat (20) t.push_back(v);
        end else begin
            t.push_back(v);
            v.asrc = (c == M_ADDI) || (c == M_LW) || (c == M_SW);
            v.alu  = (c == M_R) ? rtype_alu(fn) : ((c == M_BEQ || c == M_BNE) ? 4'd1 : 4'd0);
            if (c == M_BEQ || c == M_BNE) begin
                v.br = 1'b1; v.bne = (c == M_BNE); v.pcw = 1'b1;
            end
            t.push_back(v);
            if (c == M_LW || c == M_SW) begin
                for (int i = 0; i < lat; i++) begin
                    v = '0; v.asrc = 1'b1;
                    if (i == lat - 1 && c == M_SW) begin v.mwe = 1'b1; v.pcw = 1'b1; end
                    t.push_back(v);
                end
            end
            if (c == M_R || c == M_ADDI || c == M_LW) begin
                v = '0; v.rwe = 1'b1; v.pcw = 1'b1;
                v.rdst = (c == M_R); v.mor = (c == M_LW);
                t.push_back(v);
            end
        end
        return t;
    endfunction

    task automatic set_inst(input logic [5:0] op, input logic [5:0] fn);
        if3.opcode = op; if3.funct = fn;
        if1.opcode = op; if1.funct = fn;
    endtask

    // Called at a falling edge; holds reset for one rising edge and returns at a falling edge.
    task automatic do_reset();
        rst_b = 1'b0;
        #1;
        check_vec("reset_outputs", 0, 3, sample(1'b0), '0);
        check_vec("reset_outputs", 0, 1, sample(1'b1), '0);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    // Entered at the falling edge of a FETCH cycle; both instances must be aligned.
    task automatic run_inst(input logic [5:0] op, input logic [5:0] fn);
        trace_t t3 = build(op, fn, 3);
        trace_t t1 = build(op, fn, 1);
        int n = (t3.size() > t1.size()) ? t3.size() : t1.size();
        set_inst(op, fn);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k < t3.size()) check_vec("trace", k, 3, sample(1'b0), t3[k]);
            if (k < t1.size()) check_vec("trace", k, 1, sample(1'b1), t1[k]);
        end
        @(negedge clk);
        if (t3.size() != t1.size() || halts(op, fn)) do_reset();
    endtask

    // Measures instruction length and pc_write pulses on both instances independently.
    task automatic measure(input row_t r);
        int  len3 = -1, len1 = -1, pcw3 = 0, pcw1 = 0, ovl = 0;
        vec_t s3, s1;
        do_reset();
        set_inst(r.op, r.fn);
        for (int c = 0; c < 40 && (len3 < 0 || len1 < 0); c++) begin
            if (c > 0) @(negedge clk);
            #1;
            s3 = sample(1'b0);
            s1 = sample(1'b1);
            if (len3 < 0) begin
                if (c > 0 && s3.irw) len3 = c;
                else begin pcw3 += int'(s3.pcw); ovl += int'(s3.rwe & s3.mwe); end
            end
            if (len1 < 0) begin
                if (c > 0 && s1.irw) len1 = c;
                else begin pcw1 += int'(s1.pcw); ovl += int'(s1.rwe & s1.mwe); end
            end
        end
        check_int({r.name, "_cycles_lat3"}, len3, r.c3);
        check_int({r.name, "_cycles_lat1"}, len1, r.c1);
        check_int({r.name, "_pc_write_lat3"}, pcw3, 1);
        check_int({r.name, "_pc_write_lat1"}, pcw1, 1);
        check_int({r.name, "_write_overlap"}, ovl, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        row_t tbl[$];
        vec_t e;
        logic [5:0] rop, rfn;
        tbl.push_back('{"add",  6'h00, 6'h20, 4, 4});
        tbl.push_back('{"sub",  6'h00, 6'h22, 4, 4});
        tbl.push_back('{"and",  6'h00, 6'h24, 4, 4});
        tbl.push_back('{"or",   6'h00, 6'h25, 4, 4});
        tbl.push_back('{"slt",  6'h00, 6'h2A, 4, 4});
        tbl.push_back('{"addi", 6'h08, 6'h00, 4, 4});
        tbl.push_back('{"lw",   6'h23, 6'h00, 7, 5});
        tbl.push_back('{"sw",   6'h2B, 6'h00, 6, 4});
        tbl.push_back('{"beq",  6'h04, 6'h00, 3, 3});
        tbl.push_back('{"bne",  6'h05, 6'h00, 3, 3});
        tbl.push_back('{"j",    6'h02, 6'h00, 2, 2});
        tbl.push_back('{"jr",   6'h00, 6'h08, 2, 2});
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
        tbl.push_back('{"illegal_nop", 6'h3F, 6'h00, 2, 2});
`endif

        rst_b = 1'b0;
        set_inst(6'h00, 6'h00);
        repeat (2) @(negedge clk);

        foreach (tbl[i]) measure(tbl[i]);

        // Full cycle traces for the directed program.
        @(negedge clk);
        do_reset();
        run_inst(6'h00, 6'h20);
        run_inst(6'h23, 6'h00);
        run_inst(6'h2B, 6'h00);
        run_inst(6'h04, 6'h00);
        run_inst(6'h05, 6'h00);

        // syscall halts; one reset edge must bring the core back to FETCH.
        run_inst(6'h00, 6'h0C);
        #1;
        e = '0; e.irw = 1'b1;
        check_vec("post_halt_fetch", 0, 3, sample(1'b0), e);

        // Reset during the second MEM cycle of sw aborts the store.
        set_inst(6'h2B, 6'h00);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check_int("sw_abort_no_write_early", int'(if3.mem_write_en), 0);
        end
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check_vec("sw_abort_in_reset", 4, 3, sample(1'b0), '0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check_vec("sw_abort_fetch", 5, 3, sample(1'b0), e);
        run_inst(6'h2B, 6'h00);

        run_inst(6'h3F, 6'h00);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                int idx = $urandom_range(0, tbl.size() - 1);
                rop = tbl[idx].op;
                rfn = tbl[idx].fn;
            end else begin
                rop = 6'($urandom_range(0, 63));
                rfn = 6'($urandom_range(0, 63));
            end
            run_inst(rop, rfn);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
